jk_ff_bank: RTL and testbench

//   Parametrised, clocked successor to the single-bit JK storage element.
//   A bank of WIDTH JK flip-flops, all updated on the rising edge of one clock, with:
//   - a synchronous active-high reset and a global enable;
//   - a runtime mode select (JK / D / T / binary up-down counter);
//   - a wrap pulse and a saturating bank-activity counter.

---
 rtl/jk_ff_bank_if.sv | 26 ++
 rtl/jk_ff_bank.sv | 66 ++++++
 tb/tb_jk_ff_bank.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/jk_ff_bank_if.sv
// Control/data bundle for jk_ff_bank: per-edge command inputs and registered state outputs.
// No handshake; every signal is sampled or presented on each rising clock edge.
interface jk_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic             wrap;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, dir, j, k,
    input  q, qn, wrap, chg_cnt
  );

  modport slave (
    input  en, mode, dir, j, k,
    output q, qn, wrap, chg_cnt
  );
endinterface

// File: rtl/jk_ff_bank.sv
// Bank of WIDTH JK/D/T flops or an up-down counter, with a wrap pulse and a saturating change counter.
// Latency: one edge from inputs to q/wrap/chg_cnt; no backpressure, inputs are sampled every edge.
module jk_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  jk_ff_bank_if.slave bus
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_D     = 2'b01;
  localparam logic [1:0] MODE_T     = 2'b10;
  localparam logic [1:0] MODE_COUNT = 2'b11;

  logic [WIDTH-1:0] q_q,       q_d;
  logic             wrap_q,    wrap_d;
  logic [CNT_W-1:0] chg_cnt_q, chg_cnt_d;

  always_comb begin
    q_d       = q_q;
    wrap_d    = 1'b0;
    chg_cnt_d = chg_cnt_q;
    if (bus.en) begin
      case (bus.mode)
        MODE_JK: q_d = (bus.j & ~q_q) | (~bus.k & q_q);
        MODE_D:  q_d = bus.j;
        MODE_T:  q_d = q_q ^ bus.j;
        MODE_COUNT: begin
          if (bus.dir) begin
            q_d    = q_q + WIDTH'(1);
            wrap_d = &q_q;
          end else begin
            q_d    = q_q - WIDTH'(1);
            wrap_d = ~|q_q;
          end
        end
        default: q_d = q_q;
      endcase
      // Counter sticks at all-ones rather than rolling back to zero.
      if ((q_d != q_q) && (chg_cnt_q != {CNT_W{1'b1}})) begin
        chg_cnt_d = chg_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q       <= RESET_VAL;
      wrap_q    <= 1'b0;
      chg_cnt_q <= '0;
    end else begin
      q_q       <= q_d;
      wrap_q    <= wrap_d;
      chg_cnt_q <= chg_cnt_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.qn      = ~q_q;
  assign bus.wrap    = wrap_q;
  assign bus.chg_cnt = chg_cnt_q;

endmodule

// File: tb/tb_jk_ff_bank.sv
// Randomized + directed bench for jk_ff_bank: a driver pushes model predictions, a monitor pops and compares.
module tb_jk_ff_bank;

  logic clk;
  logic rst;

  jk_ff_bank_if #(.WIDTH(8), .CNT_W(16)) if_b ();
  jk_ff_bank_if #(.WIDTH(8), .CNT_W(2))  if_s ();

  // The narrow-counter instance sees identical stimulus so saturation can be observed.
  assign if_s.en   = if_b.en;
  assign if_s.mode = if_b.mode;
  assign if_s.dir  = if_b.dir;
  assign if_s.j    = if_b.j;
  assign if_s.k    = if_b.k;

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  jk_ff_bank #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(2)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s)
  );

  typedef struct {
    int q;
    int w;
    int c16;
    int c2;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   m_q    = 0;
  int   m_c16  = 0;
  int   m_c2   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per-bit truth tables and modular integer arithmetic.
  task automatic step(input bit r, input bit e, input int md, input bit d, input int jj, input int kk);
    int   nq;
    int   nw;
    int   jb, kb, qb, nb;
    exp_t x;
    @(posedge clk);
    #2;
    rst       = r;
    if_b.en   = e;
    if_b.mode = 2'(md);
    if_b.dir  = d;
    if_b.j    = 8'(jj);
    if_b.k    = 8'(kk);
    nq = m_q;
    nw = 0;
    if (r) begin
      nq    = 'hA5;
      m_c16 = 0;
      m_c2  = 0;
    end else if (e) begin
      case (md)
        0: begin
          nq = 0;
          for (int b = 0; b < 8; b++) begin
            jb = (jj >> b) & 1;
            kb = (kk >> b) & 1;
            qb = (m_q >> b) & 1;
            if (jb == 1 && kb == 1)  nb = 1 - qb;
            else if (jb == 1)        nb = 1;
            else if (kb == 1)        nb = 0;
            else                     nb = qb;
            nq = nq | (nb << b);
          end
        end
        1: nq = jj & 255;
        2: nq = (m_q ^ jj) & 255;
        default: begin
          if (d) begin
            nq = (m_q + 1) % 256;
            nw = (m_q == 255) ? 1 : 0;
          end else begin
            nq = (m_q + 255) % 256;
            nw = (m_q == 0) ? 1 : 0;
          end
        end
      endcase
      if (nq != m_q) begin
        if (m_c16 < 65535) m_c16++;
        if (m_c2 < 3)      m_c2++;
      end
    end
    m_q   = nq;
    x.q   = nq;
    x.w   = nw;
    x.c16 = m_c16;
    x.c2  = m_c2;
    sb.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("q",         32'(if_b.q),       32'(mon_e.q));
      chk("qn",        32'(if_b.qn),      32'(~mon_e.q & 255));
      chk("wrap",      32'(if_b.wrap),    32'(mon_e.w));
      chk("chg_cnt",   32'(if_b.chg_cnt), 32'(mon_e.c16));
      chk("q_small",   32'(if_s.q),       32'(mon_e.q));
      chk("chg_cnt_2", 32'(if_s.chg_cnt), 32'(mon_e.c2));
    end
  end

  initial begin
    rst = 1'b1;
    if_b.en = 1'b1; if_b.mode = 2'b11; if_b.dir = 1'b1; if_b.j = 8'hFF; if_b.k = 8'hFF;

    // Reset wins over enable and all-ones J/K.
    step(1, 1, 3, 1, 'hFF, 'hFF);
    step(1, 1, 0, 1, 'hFF, 'hFF);
    // JK: set, toggle, hold.
    step(0, 1, 1, 0, 'h00, 'h00);
    step(0, 1, 0, 0, 'hF0, 'h0F);
    step(0, 1, 0, 0, 'hFF, 'hFF);
    step(0, 1, 0, 0, 'h00, 'h00);
    // Disabled edges hold everything.
    for (int i = 0; i < 5; i++)
      step(0, 0, int'($urandom_range(3)), bit'($urandom_range(1)),
           int'($urandom_range(255)), int'($urandom_range(255)));
    // Count up across all-ones, then down across zero.
    step(0, 1, 1, 0, 'hFE, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 3, 0, 0, 0);
    // Toggle then immediate switch to D.
    step(0, 1, 1, 0, 'hAA, 0);
    step(0, 1, 2, 0, 'hFF, 0);
    step(0, 1, 1, 0, 'h3C, 0);
    // Saturation of the 2-bit counter, then reset mid-count.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 3, 1, 0, 0);
    step(1, 1, 3, 1, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    // Random traffic with rare resets.
    for (int i = 0; i < 300; i++)
      step(($urandom_range(39) == 0), ($urandom_range(3) != 0),
           int'($urandom_range(3)), bit'($urandom_range(1)),
           int'($urandom_range(255)), int'($urandom_range(255)));

    for (int i = 0; i < 10; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #3;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
